// File: rtl/lift_floor_ctrl.sv
// rtl/lift_floor_ctrl.sv - SCAN-style lift car controller with latched floor requests
//
// Purpose: edge-detects debounced per-floor call levels into latched requests and
// moves the car floor by floor (timed travel), opening the door at requested floors.
// Ports:
//   clk          system clock, rising edge
//   resetb       synchronous active-high reset
//   btn_clean    debounced call buttons, one level per floor
//   floor        current car floor
//   moving_up    high while travelling up
//   moving_down  high while travelling down
//   door_open    high while the door is open
//   req_pending  latched outstanding requests
module lift_floor_ctrl #(
    parameter int NFLOORS    = 4,
    parameter int FLOOR_W    = 2,
    parameter int TRAVEL_CYC = 16,
    parameter int DOOR_CYC   = 8
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic [NFLOORS-1:0] btn_clean,
    output logic [FLOOR_W-1:0] floor,
    output logic               moving_up,
    output logic               moving_down,
    output logic               door_open,
    output logic [NFLOORS-1:0] req_pending
);

    localparam int TMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int TW   = $clog2(TMAX);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    state_t             state;
    logic               dir_up;
    logic [TW-1:0]      timer;
    logic [NFLOORS-1:0] btn_prev;
    logic [NFLOORS-1:0] req_next;

    logic above, below, here;
    logic here_up, beyond_up, here_dn, beyond_dn;
    logic travel_done, door_done;
    logic clear_en;
    logic [FLOOR_W-1:0] floor_up, floor_dn, clear_floor;

    assign floor_up    = floor + FLOOR_W'(1);
    assign floor_dn    = floor - FLOOR_W'(1);
    assign travel_done = (timer == TW'(TRAVEL_CYC - 1));
    assign door_done   = (timer == TW'(DOOR_CYC - 1));

    // Request summaries relative to the current floor and to the floor the car
    // would reach at the end of the current travel step.
    always_comb begin
        above     = 1'b0;
        below     = 1'b0;
        here      = 1'b0;
        here_up   = 1'b0;
        beyond_up = 1'b0;
        here_dn   = 1'b0;
        beyond_dn = 1'b0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (i >  int'(floor))     above     = above     | req_pending[i];
            if (i <  int'(floor))     below     = below     | req_pending[i];
            if (i == int'(floor))     here      = here      | req_pending[i];
            if (i == int'(floor) + 1) here_up   = here_up   | req_pending[i];
            if (i >  int'(floor) + 1) beyond_up = beyond_up | req_pending[i];
            if (i == int'(floor) - 1) here_dn   = here_dn   | req_pending[i];
            if (i <  int'(floor) - 1) beyond_dn = beyond_dn | req_pending[i];
        end
    end

    // The served floor's request is cleared on the edge that enters DOOR (at the
    // floor being arrived at) and on every edge leaving a DOOR cycle, so a clear
    // always beats a simultaneous rise on that bit.
    always_comb begin
        clear_en    = 1'b0;
        clear_floor = floor;
        case (state)
            IDLE:      clear_en = here;
            MOVE_UP:   begin
                clear_en    = travel_done & here_up;
                clear_floor = floor_up;
            end
            MOVE_DOWN: begin
                clear_en    = travel_done & here_dn;
                clear_floor = floor_dn;
            end
            DOOR:      clear_en = 1'b1;
            default:   clear_en = 1'b0;
        endcase
        for (int i = 0; i < NFLOORS; i++) begin
            req_next[i] = (req_pending[i] | (btn_clean[i] & ~btn_prev[i]))
                          & ~(clear_en && (i == int'(clear_floor)));
        end
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            state       <= IDLE;
            floor       <= '0;
            dir_up      <= 1'b1;
            timer       <= '0;
            btn_prev    <= '0;
            req_pending <= '0;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            door_open   <= 1'b0;
        end else begin
            btn_prev    <= btn_clean;
            req_pending <= req_next;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (here) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                    end else if (above && (dir_up || !below)) begin
                        state     <= MOVE_UP;
                        dir_up    <= 1'b1;
                        moving_up <= 1'b1;
                    end else if (below) begin
                        state       <= MOVE_DOWN;
                        dir_up      <= 1'b0;
                        moving_down <= 1'b1;
                    end
                end
                MOVE_UP: begin
                    if (travel_done) begin
                        timer <= '0;
                        floor <= floor_up;
                        if (here_up) begin
                            state     <= DOOR;
                            moving_up <= 1'b0;
                            door_open <= 1'b1;
                        end else if (!beyond_up) begin
                            state     <= IDLE;
                            moving_up <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                MOVE_DOWN: begin
                    if (travel_done) begin
                        timer <= '0;
                        floor <= floor_dn;
                        if (here_dn) begin
                            state       <= DOOR;
                            moving_down <= 1'b0;
                            door_open   <= 1'b1;
                        end else if (!beyond_dn) begin
                            state       <= IDLE;
                            moving_down <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DOOR: begin
                    if (door_done) begin
                        timer     <= '0;
                        state     <= IDLE;
                        door_open <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    timer       <= '0;
                    moving_up   <= 1'b0;
                    moving_down <= 1'b0;
                    door_open   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lift_floor_ctrl.sv
// tb/tb_lift_floor_ctrl.sv - scoreboard bench for lift_floor_ctrl against a timestamp-based car model
module tb_lift_floor_ctrl;

    localparam int NF = 4;
    localparam int FW = 2;
    localparam int TR = 16;
    localparam int DR = 8;

    typedef struct packed {
        logic [FW-1:0] floor;
        logic          up;
        logic          down;
        logic          door;
        logic [NF-1:0] req;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetb = 1'b1;
    logic [NF-1:0] btn_clean = '0;
    logic [FW-1:0] floor;
    logic          moving_up, moving_down, door_open;
    logic [NF-1:0] req_pending;

    lift_floor_ctrl #(.NFLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYC(TR), .DOOR_CYC(DR)) dut (
        .clk(clk), .resetb(resetb), .btn_clean(btn_clean), .floor(floor),
        .moving_up(moving_up), .moving_down(moving_down), .door_open(door_open),
        .req_pending(req_pending)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Car model: mode 0 = parked, 1 = travelling, 2 = door open.
    // Phases end at absolute cycle stamps rather than via a counter.
    int     m_mode;
    int     m_f;
    bit     m_up;
    bit     m_req[NF];
    bit     m_prev[NF];
    longint cyc = 0;
    longint deadline;

    function automatic bit any_in(int lo, int hi);
        bit r = 0;
        for (int i = 0; i < NF; i++) if (i >= lo && i <= hi && m_req[i]) r = 1;
        return r;
    endfunction

    task automatic model_step(input logic [NF-1:0] b, input logic r);
        exp_t e;
        bit   was_door;
        cyc++;
        if (r) begin
            m_mode = 0; m_f = 0; m_up = 1;
            for (int i = 0; i < NF; i++) begin m_req[i] = 0; m_prev[i] = 0; end
        end else begin
            was_door = (m_mode == 2);
            case (m_mode)
                0: begin
                    if (m_req[m_f]) begin
                        m_mode = 2; deadline = cyc + DR;
                    end else if (any_in(m_f + 1, NF - 1) && (m_up || !any_in(0, m_f - 1))) begin
                        m_mode = 1; m_up = 1; deadline = cyc + TR;
                    end else if (any_in(0, m_f - 1)) begin
                        m_mode = 1; m_up = 0; deadline = cyc + TR;
                    end
                end
                1: begin
                    if (cyc == deadline) begin
                        m_f = m_up ? m_f + 1 : m_f - 1;
                        if (m_req[m_f]) begin
                            m_mode = 2; deadline = cyc + DR;
                        end else if (m_up ? any_in(m_f + 1, NF - 1) : any_in(0, m_f - 1)) begin
                            deadline = cyc + TR;
                        end else begin
                            m_mode = 0;
                        end
                    end
                end
                default: if (cyc == deadline) m_mode = 0;
            endcase
            for (int i = 0; i < NF; i++) begin
                if (b[i] && !m_prev[i]) m_req[i] = 1;
                m_prev[i] = b[i];
            end
            if (was_door || m_mode == 2) m_req[m_f] = 0;
        end
        e.floor = FW'(m_f);
        e.up    = (m_mode == 1) && m_up;
        e.down  = (m_mode == 1) && !m_up;
        e.door  = (m_mode == 2);
        for (int i = 0; i < NF; i++) e.req[i] = m_req[i];
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic [NF-1:0] b, input logic r);
        @(negedge clk);
        btn_clean = b;
        resetb    = r;
        @(posedge clk);
        model_step(b, r);
    endtask

    task automatic idle_for(input int n, input logic [NF-1:0] b);
        for (int k = 0; k < n; k++) cycle(b, 1'b0);
    endtask

    // Monitor: outputs are presented every cycle; compare half a clock after the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e, a;
            e = exp_q.pop_front();
            a = {floor, moving_up, moving_down, door_open, req_pending};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs @%0t: got floor=%0d up=%b down=%b door=%b req=%b, expected floor=%0d up=%b down=%b door=%b req=%b",
                         $time, a.floor, a.up, a.down, a.door, a.req,
                         e.floor, e.up, e.down, e.door, e.req);
            end
        end
    end

    initial begin
        logic [NF-1:0] b;
        // Reset and quiet idle.
        for (int k = 0; k < 4; k++) cycle('0, 1'b1);
        idle_for(20, '0);
        // Call to floor 2 from floor 0.
        cycle(4'b0100, 1'b0);
        idle_for(60, '0);
        // Go back to floor 0 and press it while parked there.
        cycle(4'b0001, 1'b0);
        idle_for(80, '0);
        cycle(4'b0001, 1'b0);
        idle_for(20, '0);
        // Park at floor 1 (dir up), then request 0 and 3 together.
        cycle(4'b0010, 1'b0);
        idle_for(40, '0);
        cycle(4'b1001, 1'b0);
        idle_for(150, '0);
        // Hold floor 3 through a full service; press current floor during door.
        idle_for(150, 4'b1000);
        idle_for(20, '0);
        cycle(4'b0001, 1'b0);
        idle_for(55, '0);
        cycle(4'b0001, 1'b0);
        idle_for(5, '0);
        // Reset mid-move.
        cycle(4'b1000, 1'b0);
        idle_for(10, '0);
        cycle('0, 1'b1);
        idle_for(10, '0);
        // Random traffic with occasional resets.
        b = '0;
        for (int k = 0; k < 6000; k++) begin
            for (int i = 0; i < NF; i++) if ($urandom_range(0, 19) == 0) b[i] = ~b[i];
            cycle(b, ($urandom_range(0, 1499) == 0));
        end
        idle_for(200, '0);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
